// File: rtl/nes_pad_reader_pkg.sv
// Shared constants for the gamepad reader: button bit positions, FSM encoding
// and the board clock frequency also used by the VGA timing block.
package nes_pad_reader_pkg;

  localparam int CLK_HZ_DEFAULT = 25_000_000;

  localparam int NUM_BUTTONS = 8;
  localparam int BTN_A       = 0;
  localparam int BTN_B       = 1;
  localparam int BTN_SELECT  = 2;
  localparam int BTN_START   = 3;
  localparam int BTN_UP      = 4;
  localparam int BTN_DOWN    = 5;
  localparam int BTN_LEFT    = 6;
  localparam int BTN_RIGHT   = 7;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_LATCH  = 2'd1;
  localparam logic [1:0] ST_SHIFT  = 2'd2;
  localparam logic [1:0] ST_UPDATE = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; the reset value lets
// each input come out of reset in its inactive level.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/nes_pad_reader.sv
// Polls an NES serial gamepad once per poll period and presents the eight
// button levels (1 = pressed) with a one-cycle valid strobe per completed read.
module nes_pad_reader
  import nes_pad_reader_pkg::*;
#(
  parameter int CLK_HZ          = CLK_HZ_DEFAULT,
  parameter int POLL_HZ         = 60,
  parameter int HALF_BIT_CYCLES = 150
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pad_data,
  output logic pad_latch,
  output logic pad_clk,
  output logic A,
  output logic B,
  output logic select,
  output logic start,
  output logic up,
  output logic down,
  output logic left,
  output logic right,
  output logic valid
);

  localparam int POLL_CYCLES = CLK_HZ / POLL_HZ;
  localparam int PCW         = $clog2(POLL_CYCLES);
  localparam int PW          = $clog2(2 * HALF_BIT_CYCLES);

  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_CYCLES - 1);
  localparam logic [PW-1:0]  PH_LAST   = PW'(2 * HALF_BIT_CYCLES - 1);
  localparam logic [PW-1:0]  PH_HALF   = PW'(HALF_BIT_CYCLES);

  if (!(POLL_CYCLES > 20 * HALF_BIT_CYCLES + 4)) begin : g_poll_check
    $error("nes_pad_reader: poll period too short for one pad read");
  end

  logic                   w_pad_data_sync;
  logic                   w_pressed;
  logic                   w_tick;
  logic                   w_slot_end;
  logic [1:0]             w_state_next;
  logic [PW-1:0]          w_phase_next;
  logic [2:0]             w_idx_next;
  logic [NUM_BUTTONS-1:0] w_shift_next;
  logic                   w_pad_clk_next;

  logic [PCW-1:0]         r_poll_cnt;
  logic [1:0]             r_state;
  logic [PW-1:0]          r_phase;
  logic [2:0]             r_idx;
  logic [NUM_BUTTONS-1:0] r_shift;
  logic [NUM_BUTTONS-1:0] r_buttons;
  logic                   r_valid;
  logic                   r_pad_latch;
  logic                   r_pad_clk;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_sync_data (
    .i_clk   (clk),
    .i_rst_n (reset_n),
    .i_d     (pad_data),
    .o_q     (w_pad_data_sync)
  );

  assign w_pressed = ~w_pad_data_sync;
  assign w_tick    = (r_poll_cnt == POLL_LAST);

  always_comb begin
    w_state_next = r_state;
    w_phase_next = r_phase;
    w_idx_next   = r_idx;
    w_slot_end   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_tick) begin
          w_state_next = ST_LATCH;
          w_phase_next = '0;
        end
      end
      ST_LATCH: begin
        if (r_phase == PH_LAST) begin
          w_state_next = ST_SHIFT;
          w_phase_next = '0;
          w_idx_next   = '0;
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (r_phase == PH_LAST) begin
          w_slot_end   = 1'b1;
          w_phase_next = '0;
          if (r_idx == 3'd7) w_state_next = ST_UPDATE;
          else               w_idx_next   = r_idx + 1'b1;
        end else begin
          w_phase_next = r_phase + 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase

    // Slot 7's bit is merged here so the buttons can load on the same edge.
    w_shift_next = r_shift;
    if (w_slot_end) w_shift_next[r_idx] = w_pressed;

    w_pad_clk_next = (w_state_next == ST_SHIFT) && (w_idx_next != 3'd0) &&
                     (w_phase_next < PH_HALF);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_poll_cnt  <= '0;
      r_state     <= ST_IDLE;
      r_phase     <= '0;
      r_idx       <= '0;
      r_shift     <= '0;
      r_buttons   <= '0;
      r_valid     <= 1'b0;
      r_pad_latch <= 1'b0;
      r_pad_clk   <= 1'b0;
    end else begin
      r_poll_cnt  <= w_tick ? '0 : r_poll_cnt + 1'b1;
      r_state     <= w_state_next;
      r_phase     <= w_phase_next;
      r_idx       <= w_idx_next;
      r_shift     <= w_shift_next;
      r_valid     <= (w_state_next == ST_UPDATE);
      r_pad_latch <= (w_state_next == ST_LATCH);
      r_pad_clk   <= w_pad_clk_next;
      if (w_state_next == ST_UPDATE) r_buttons <= w_shift_next;
    end
  end

  assign pad_latch = r_pad_latch;
  assign pad_clk   = r_pad_clk;
  assign valid     = r_valid;
  assign A         = r_buttons[BTN_A];
  assign B         = r_buttons[BTN_B];
  assign select    = r_buttons[BTN_SELECT];
  assign start     = r_buttons[BTN_START];
  assign up        = r_buttons[BTN_UP];
  assign down      = r_buttons[BTN_DOWN];
  assign left      = r_buttons[BTN_LEFT];
  assign right     = r_buttons[BTN_RIGHT];

endmodule

// File: tb/tb_nes_pad_reader.sv
// Directed bench for nes_pad_reader with a behavioural NES pad model
// (CLK_HZ=1000, POLL_HZ=10, HALF_BIT_CYCLES=2).
module tb_nes_pad_reader;

  logic clk = 1'b0;
  logic reset_n;
  logic pad_data;
  logic pad_latch, pad_clk, valid;
  logic A, B, select, start, up, down, left, right;
  logic [7:0] btns;

  logic [7:0] pad_btn = 8'h00;
  logic       pad_conn = 1'b0;
  logic       glitch_en = 1'b0;
  logic       glitch_val = 1'b0;
  int         pad_pos = 0;
  logic       w_model;

  int cyc;
  int overlap_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  nes_pad_reader #(
    .CLK_HZ          (1000),
    .POLL_HZ         (10),
    .HALF_BIT_CYCLES (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .pad_data  (pad_data),
    .pad_latch (pad_latch),
    .pad_clk   (pad_clk),
    .A         (A),
    .B         (B),
    .select    (select),
    .start     (start),
    .up        (up),
    .down      (down),
    .left      (left),
    .right     (right),
    .valid     (valid)
  );

  assign btns = {right, left, down, up, start, select, B, A};

  // Pad model: parallel load while latched, shift on each pad_clk rise.
  always @(posedge pad_latch or posedge pad_clk) begin
    if (pad_latch) pad_pos <= 0;
    else           pad_pos <= pad_pos + 1;
  end

  always_comb w_model = (pad_pos < 8) ? ~pad_btn[pad_pos[2:0]] : 1'b0;
  assign pad_data = glitch_en ? glitch_val : (pad_conn ? w_model : 1'b1);

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if (pad_latch && pad_clk) overlap_cnt <= overlap_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else begin
      n_pass++;
      $display("check %s: %0h ok", tag, got);
    end
  endtask

  task automatic wait_frame(output int lstart, output int llen, output int rises,
                            output int vcyc, output logic [7:0] pre_btn);
    logic prev_clk;
    bit   seen;
    seen     = 1'b0;
    lstart   = -1;
    llen     = 0;
    rises    = 0;
    vcyc     = -1;
    pre_btn  = btns;
    prev_clk = pad_clk;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (pad_latch) begin
        if (!seen) lstart = cyc;
        seen = 1'b1;
        llen++;
      end
      if (pad_clk && !prev_clk) rises++;
      prev_clk = pad_clk;
      if (valid) begin
        vcyc = cyc;
        break;
      end
      pre_btn = btns;
    end
  endtask

  int         ls, ll, rs, vc, last_vc;
  logic [7:0] pre;
  bit         found;
  logic       prev_pc;

  initial begin
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_buttons", {24'd0, btns}, 32'h0);
    check("rst_valid", {31'd0, valid}, 32'h0);
    check("rst_latch", {31'd0, pad_latch}, 32'h0);
    check("rst_padclk", {31'd0, pad_clk}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // Frame 1: disconnected pad reads as nothing pressed.
    wait_frame(ls, ll, rs, vc, pre);
    check("f1_latch_start", ls, 100);
    check("f1_latch_len", ll, 4);
    check("f1_valid_cycle", vc, 136);
    check("f1_clk_rises", rs, 7);
    check("f1_buttons", {24'd0, btns}, 32'h00);
    @(negedge clk);
    check("f1_valid_pulse", {31'd0, valid}, 32'h0);
    last_vc = vc;

    // Frame 2: A only.
    pad_conn = 1'b1;
    pad_btn  = 8'h01;
    wait_frame(ls, ll, rs, vc, pre);
    check("f2_pre_buttons", {24'd0, pre}, 32'h00);
    check("f2_buttons", {24'd0, btns}, 32'h01);
    check("f2_period", vc - last_vc, 100);
    last_vc = vc;

    // Frame 3: up + left.
    pad_btn = 8'h50;
    wait_frame(ls, ll, rs, vc, pre);
    check("f3_pre_buttons", {24'd0, pre}, 32'h01);
    check("f3_buttons", {24'd0, btns}, 32'h50);
    check("f3_clk_rises", rs, 7);
    check("f3_latch_len", ll, 4);
    check("f3_period", vc - last_vc, 100);
    last_vc = vc;

    // Frames 4/5: A then right.
    pad_btn = 8'h01;
    wait_frame(ls, ll, rs, vc, pre);
    check("f4_pre_buttons", {24'd0, pre}, 32'h50);
    check("f4_buttons", {24'd0, btns}, 32'h01);
    check("f4_period", vc - last_vc, 100);
    last_vc = vc;
    pad_btn = 8'h80;
    wait_frame(ls, ll, rs, vc, pre);
    check("f5_pre_buttons", {24'd0, pre}, 32'h01);
    check("f5_buttons", {24'd0, btns}, 32'h80);
    check("f5_period", vc - last_vc, 100);

    // Frame 6: noise on pad_data from idle through the end of the latch pulse.
    pad_btn   = 8'h2C;
    glitch_en = 1'b1;
    found     = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      glitch_val = 1'($urandom_range(0, 1));
      if (pad_latch) found = 1'b1;
      else if (found) break;
    end
    glitch_en = 1'b0;
    check("f6_latch_seen", {31'd0, found}, 32'h1);
    wait_frame(ls, ll, rs, vc, pre);
    check("f6_pre_buttons", {24'd0, pre}, 32'h80);
    check("f6_buttons", {24'd0, btns}, 32'h2C);

    // Reset asserted during slot 4 (4th pad_clk rise of the frame).
    found   = 1'b0;
    rs      = 0;
    prev_pc = pad_clk;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (pad_clk && !prev_pc) rs++;
      prev_pc = pad_clk;
      if (rs == 4) begin
        found = 1'b1;
        break;
      end
    end
    check("slot4_reached", {31'd0, found}, 32'h1);
    check("pre_rst_padclk", {31'd0, pad_clk}, 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_buttons", {24'd0, btns}, 32'h00);
    check("mid_rst_padclk", {31'd0, pad_clk}, 32'h0);
    check("mid_rst_latch", {31'd0, pad_latch}, 32'h0);
    check("mid_rst_valid", {31'd0, valid}, 32'h0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_frame(ls, ll, rs, vc, pre);
    check("f7_latch_start", ls, 100);
    check("f7_valid_cycle", vc, 136);
    check("f7_pre_buttons", {24'd0, pre}, 32'h00);
    check("f7_buttons", {24'd0, btns}, 32'h2C);

    check("latch_clk_overlap", overlap_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
